// File: rtl/gcm_decrypt_scheduler.sv
// Round-robin scheduler sharing one aes_gcm_decrypt engine between NUM_REQ requesters.
// Grants one owner, clears the engine for two cycles, streams the owner's ciphertext,
// forwards plaintext tagged with the owner ID and reports a per-session result.
// Optional WAIT watchdog enabled by defining GCM_SCHED_TIMEOUT_EN.
module gcm_decrypt_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned LEN_W   = 16,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  output logic [NUM_REQ-1:0]     req_grant,
  input  logic [NUM_REQ*32-1:0]  src_data,
  input  logic [NUM_REQ-1:0]     src_valid,
  output logic [NUM_REQ-1:0]     src_ready,
  output logic [ID_W-1:0]        eng_sel,
  output logic                   eng_rst_n,
  output logic [31:0]            eng_ct,
  output logic                   eng_ct_valid,
  input  logic [31:0]            eng_pt,
  input  logic                   eng_pt_valid,
  input  logic                   eng_auth_success,
  input  logic                   eng_tag_valid,
  input  logic                   eng_complete,
  output logic [31:0]            pt_data,
  output logic                   pt_valid,
  output logic [ID_W-1:0]        pt_id,
  output logic                   done_valid,
  output logic [ID_W-1:0]        done_id,
  output logic                   done_auth_ok,
  output logic                   done_len_err,
  output logic                   done_timeout
);

  localparam int unsigned DATA_W = 32;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_REPORT = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [ID_W-1:0]    owner_q, owner_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic               clr_q, clr_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic               eng_rst_n_q, eng_rst_n_d;
  logic [DATA_W-1:0]  eng_ct_q, eng_ct_d;
  logic               eng_ct_valid_q, eng_ct_valid_d;
  logic [DATA_W-1:0]  pt_data_q, pt_data_d;
  logic               pt_valid_q, pt_valid_d;
  logic [ID_W-1:0]    pt_id_q, pt_id_d;
  logic               done_valid_q, done_valid_d;
  logic [ID_W-1:0]    done_id_q, done_id_d;
  logic               done_auth_ok_q, done_auth_ok_d;
  logic               done_len_err_q, done_len_err_d;

`ifdef GCM_SCHED_TIMEOUT_EN
  localparam int unsigned WCNT_W = $clog2(TIMEOUT + 1);
  logic [WCNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               done_timeout_q, done_timeout_d;
`endif

  logic [ID_W-1:0]    pick_c;
  logic               pick_hit_c;
  logic               accept_c;

  // First requesting index at or after rr_ptr, wrapping around
  always_comb begin
    logic [ID_W-1:0] idx;
    idx        = '0;
    pick_c     = '0;
    pick_hit_c = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = ID_W'((32'(rr_ptr_q) + i) % NUM_REQ);
      if (!pick_hit_c && req_valid[idx]) begin
        pick_hit_c = 1'b1;
        pick_c     = idx;
      end
    end
  end

  // Only the owner may be ready, and only while words remain
  always_comb begin
    src_ready = '0;
    if (state_q == S_STREAM && remaining_q != '0) src_ready[owner_q] = 1'b1;
  end

  assign accept_c = src_valid[owner_q] & src_ready[owner_q];

  // Next-state and registered-output logic
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    grant_d        = grant_q;
    remaining_d    = remaining_q;
    clr_d          = clr_q;
    rr_ptr_d       = rr_ptr_q;
    eng_rst_n_d    = 1'b1;
    eng_ct_d       = eng_ct_q;
    eng_ct_valid_d = 1'b0;
    pt_data_d      = eng_pt;
    pt_valid_d     = eng_pt_valid;
    pt_id_d        = owner_q;
    done_valid_d   = 1'b0;
    done_id_d      = done_id_q;
    done_auth_ok_d = done_auth_ok_q;
    done_len_err_d = done_len_err_q;
`ifdef GCM_SCHED_TIMEOUT_EN
    wait_cnt_d     = wait_cnt_q;
    done_timeout_d = done_timeout_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (pick_hit_c) begin
          owner_d     = pick_c;
          grant_d     = NUM_REQ'(1) << pick_c;
          remaining_d = req_len[pick_c*LEN_W +: LEN_W];
          clr_d       = 1'b0;
          eng_rst_n_d = 1'b0;
          state_d     = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (!clr_q) begin
          clr_d       = 1'b1;
          eng_rst_n_d = 1'b0;
        end else if (remaining_q == '0) begin
          done_valid_d   = 1'b1;
          done_id_d      = owner_q;
          done_auth_ok_d = 1'b0;
          done_len_err_d = 1'b1;
`ifdef GCM_SCHED_TIMEOUT_EN
          done_timeout_d = 1'b0;
`endif
          state_d        = S_REPORT;
        end else begin
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (accept_c) begin
          eng_ct_d       = src_data[owner_q*DATA_W +: DATA_W];
          eng_ct_valid_d = 1'b1;
          remaining_d    = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
`ifdef GCM_SCHED_TIMEOUT_EN
            wait_cnt_d = '0;
`endif
            state_d    = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (eng_complete) begin
          done_valid_d   = 1'b1;
          done_id_d      = owner_q;
          done_auth_ok_d = eng_auth_success & eng_tag_valid;
          done_len_err_d = 1'b0;
`ifdef GCM_SCHED_TIMEOUT_EN
          done_timeout_d = 1'b0;
`endif
          state_d        = S_REPORT;
        end
`ifdef GCM_SCHED_TIMEOUT_EN
        else if (wait_cnt_q == WCNT_W'(TIMEOUT - 1)) begin
          done_valid_d   = 1'b1;
          done_id_d      = owner_q;
          done_auth_ok_d = 1'b0;
          done_len_err_d = 1'b0;
          done_timeout_d = 1'b1;
          state_d        = S_REPORT;
        end else begin
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
`endif
      end
      S_REPORT: begin
        grant_d  = '0;
        rr_ptr_d = ID_W'((32'(owner_q) + 1) % NUM_REQ);
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      owner_q        <= '0;
      grant_q        <= '0;
      remaining_q    <= '0;
      clr_q          <= 1'b0;
      rr_ptr_q       <= '0;
      eng_rst_n_q    <= 1'b0;
      eng_ct_q       <= '0;
      eng_ct_valid_q <= 1'b0;
      pt_data_q      <= '0;
      pt_valid_q     <= 1'b0;
      pt_id_q        <= '0;
      done_valid_q   <= 1'b0;
      done_id_q      <= '0;
      done_auth_ok_q <= 1'b0;
      done_len_err_q <= 1'b0;
`ifdef GCM_SCHED_TIMEOUT_EN
      wait_cnt_q     <= '0;
      done_timeout_q <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      grant_q        <= grant_d;
      remaining_q    <= remaining_d;
      clr_q          <= clr_d;
      rr_ptr_q       <= rr_ptr_d;
      eng_rst_n_q    <= eng_rst_n_d;
      eng_ct_q       <= eng_ct_d;
      eng_ct_valid_q <= eng_ct_valid_d;
      pt_data_q      <= pt_data_d;
      pt_valid_q     <= pt_valid_d;
      pt_id_q        <= pt_id_d;
      done_valid_q   <= done_valid_d;
      done_id_q      <= done_id_d;
      done_auth_ok_q <= done_auth_ok_d;
      done_len_err_q <= done_len_err_d;
`ifdef GCM_SCHED_TIMEOUT_EN
      wait_cnt_q     <= wait_cnt_d;
      done_timeout_q <= done_timeout_d;
`endif
    end
  end

  assign req_grant    = grant_q;
  assign eng_sel      = owner_q;
  assign eng_rst_n    = eng_rst_n_q;
  assign eng_ct       = eng_ct_q;
  assign eng_ct_valid = eng_ct_valid_q;
  assign pt_data      = pt_data_q;
  assign pt_valid     = pt_valid_q;
  assign pt_id        = pt_id_q;
  assign done_valid   = done_valid_q;
  assign done_id      = done_id_q;
  assign done_auth_ok = done_auth_ok_q;
  assign done_len_err = done_len_err_q;
`ifdef GCM_SCHED_TIMEOUT_EN
  assign done_timeout = done_timeout_q;
`else
  assign done_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_gcm_decrypt_scheduler.sv
// Directed bench for gcm_decrypt_scheduler; inputs change and outputs are sampled on negedge.
module tb_gcm_decrypt_scheduler;

  localparam int unsigned NR = 4;
  localparam int unsigned IW = 2;
  localparam int unsigned LW = 16;

  logic           clk;
  logic           reset_n;
  logic [NR-1:0]  req_valid;
  logic [NR*LW-1:0] req_len;
  logic [NR-1:0]  req_grant;
  logic [NR*32-1:0] src_data;
  logic [NR-1:0]  src_valid;
  logic [NR-1:0]  src_ready;
  logic [IW-1:0]  eng_sel;
  logic           eng_rst_n;
  logic [31:0]    eng_ct;
  logic           eng_ct_valid;
  logic [31:0]    eng_pt;
  logic           eng_pt_valid;
  logic           eng_auth_success;
  logic           eng_tag_valid;
  logic           eng_complete;
  logic [31:0]    pt_data;
  logic           pt_valid;
  logic [IW-1:0]  pt_id;
  logic           done_valid;
  logic [IW-1:0]  done_id;
  logic           done_auth_ok;
  logic           done_len_err;
  logic           done_timeout;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [31:0] word_tab [8];

  gcm_decrypt_scheduler #(.NUM_REQ(NR), .ID_W(IW), .LEN_W(LW), .TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_len(req_len), .req_grant(req_grant),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .eng_sel(eng_sel), .eng_rst_n(eng_rst_n), .eng_ct(eng_ct), .eng_ct_valid(eng_ct_valid),
    .eng_pt(eng_pt), .eng_pt_valid(eng_pt_valid), .eng_auth_success(eng_auth_success),
    .eng_tag_valid(eng_tag_valid), .eng_complete(eng_complete),
    .pt_data(pt_data), .pt_valid(pt_valid), .pt_id(pt_id),
    .done_valid(done_valid), .done_id(done_id), .done_auth_ok(done_auth_ok),
    .done_len_err(done_len_err), .done_timeout(done_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_len(input int id, input int len);
    req_len[id*LW +: LW] = LW'(len);
  endtask

  // Runs one granted session: waits for grant, streams word_tab, completes the engine
  task automatic session(input int id, input int len, input bit toggle,
                         input bit auth, input bit tag, input bit drop);
    int got, sent, budget;
    bit phase, granted;
    logic [NR-1:0] exp_g;
    exp_g = NR'(1) << id;
    granted = 1'b0;
    for (int n = 0; n < 8 && !granted; n++) begin
      tick();
      if (req_grant != '0) granted = 1'b1;
    end
    total_cnt++;
    if (req_grant !== exp_g || eng_sel !== IW'(id))
      $display("FAIL grant id%0d: got grant=%b sel=%0d expected grant=%b sel=%0d", id, req_grant, eng_sel, exp_g, id);
    else pass_cnt++;
    if (drop) req_valid[id] = 1'b0;
    got = 0; sent = 0; budget = 0; phase = 1'b1;
    while (got < len && budget < 4*len + 16) begin
      if (eng_ct_valid === 1'b1) begin
        total_cnt++;
        if (eng_ct !== word_tab[got])
          $display("FAIL eng_ct id%0d word%0d: got %h expected %h", id, got, eng_ct, word_tab[got]);
        else pass_cnt++;
        got++;
      end
      if (got < len) begin
        src_valid[id] = (sent < len) && (!toggle || phase);
        src_data[id*32 +: 32] = word_tab[sent < 8 ? sent : 7];
        if (src_valid[id] && src_ready[id]) sent++;
        if (src_ready[id]) phase = ~phase;
        tick();
        budget++;
      end
    end
    src_valid = '0;
    total_cnt++;
    if (got != len || src_ready !== '0)
      $display("FAIL stream id%0d: got words=%0d ready=%b expected words=%0d ready=0", id, got, src_ready, len);
    else pass_cnt++;
    eng_complete = 1'b1; eng_auth_success = auth; eng_tag_valid = tag;
    tick();
    eng_complete = 1'b0; eng_auth_success = 1'b0; eng_tag_valid = 1'b0;
    total_cnt++;
    if ({done_valid, done_id, done_auth_ok, done_len_err, done_timeout, eng_ct_valid, req_grant}
        !== {1'b1, IW'(id), auth & tag, 1'b0, 1'b0, 1'b0, exp_g})
      $display("FAIL done id%0d: got v=%b id=%0d ok=%b lerr=%b to=%b ctv=%b gnt=%b expected v=1 id=%0d ok=%b lerr=0 to=0 ctv=0 gnt=%b",
               id, done_valid, done_id, done_auth_ok, done_len_err, done_timeout, eng_ct_valid, req_grant, id, auth & tag, exp_g);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (done_valid !== 1'b0 || req_grant !== '0)
      $display("FAIL release id%0d: got done_valid=%b grant=%b expected 0 0", id, done_valid, req_grant);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req_valid = '0; req_len = '0; src_data = '0; src_valid = '0;
    eng_pt = '0; eng_pt_valid = 1'b0; eng_auth_success = 1'b0;
    eng_tag_valid = 1'b0; eng_complete = 1'b0;
    repeat (3) tick();
    total_cnt++;
    if ({req_grant, src_ready, eng_sel, eng_rst_n, eng_ct, eng_ct_valid, pt_data, pt_valid, pt_id,
         done_valid, done_id, done_auth_ok, done_len_err, done_timeout} !== '0)
      $display("FAIL reset_values: got grant=%b ready=%b rstn=%b ct=%h ctv=%b pt=%h ptv=%b dv=%b expected all 0",
               req_grant, src_ready, eng_rst_n, eng_ct, eng_ct_valid, pt_data, pt_valid, done_valid);
    else pass_cnt++;
    reset_n = 1'b1;
    tick();
    total_cnt++;
    if (eng_rst_n !== 1'b1 || req_grant !== '0)
      $display("FAIL idle_after_reset: got eng_rst_n=%b grant=%b expected 1 0000", eng_rst_n, req_grant);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 4; i++) set_len(i, 1);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      word_tab[0] = 32'hA0 + 32'(k);
      session(order[k], 1, 1'b0, 1'b1, 1'b1, 1'b0);
    end
    req_valid = '0;
  endtask

  task automatic test_single();
    set_len(0, 3);
    word_tab[0] = 32'h11; word_tab[1] = 32'h22; word_tab[2] = 32'h33;
    req_valid = 4'b0001;
    session(0, 3, 1'b0, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_zero_len();
    set_len(2, 0);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    total_cnt++;
    if (req_grant !== 4'b0100 || eng_sel !== 2'd2 || eng_rst_n !== 1'b0 || src_ready !== '0)
      $display("FAIL zero_t1: got grant=%b sel=%0d rstn=%b ready=%b expected 0100 2 0 0000", req_grant, eng_sel, eng_rst_n, src_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (eng_rst_n !== 1'b0 || src_ready !== '0 || done_valid !== 1'b0)
      $display("FAIL zero_t2: got rstn=%b ready=%b dv=%b expected 0 0000 0", eng_rst_n, src_ready, done_valid);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({done_valid, done_id, done_len_err, done_auth_ok, done_timeout, eng_rst_n, src_ready}
        !== {1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000})
      $display("FAIL zero_t3: got dv=%b id=%0d lerr=%b ok=%b to=%b rstn=%b ready=%b expected 1 2 1 0 0 1 0000",
               done_valid, done_id, done_len_err, done_auth_ok, done_timeout, eng_rst_n, src_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (done_valid !== 1'b0 || req_grant !== '0 || done_len_err !== 1'b1 || done_id !== 2'd2)
      $display("FAIL zero_hold: got dv=%b grant=%b lerr=%b id=%0d expected 0 0000 1 2", done_valid, req_grant, done_len_err, done_id);
    else pass_cnt++;
  endtask

  task automatic test_auth_fail_backpressure();
    set_len(1, 4);
    for (int i = 0; i < 4; i++) word_tab[i] = 32'h1000_0000 + 32'(i);
    req_valid = 4'b0010;
    session(1, 4, 1'b1, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_pt_forward();
    eng_pt = 32'hDEAD_BEEF; eng_pt_valid = 1'b1;
    tick();
    eng_pt_valid = 1'b0;
    total_cnt++;
    if (pt_data !== 32'hDEAD_BEEF || pt_valid !== 1'b1 || pt_id !== 2'd1)
      $display("FAIL pt_forward: got data=%h v=%b id=%0d expected deadbeef 1 1", pt_data, pt_valid, pt_id);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (pt_valid !== 1'b0)
      $display("FAIL pt_drop: got pt_valid=%b expected 0", pt_valid);
    else pass_cnt++;
  endtask

`ifdef GCM_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    bit seen;
    set_len(3, 1);
    req_valid = 4'b1000;
    seen = 1'b0;
    for (int n = 0; n < 8 && !seen; n++) begin
      tick();
      if (req_grant != '0) seen = 1'b1;
    end
    req_valid = '0;
    seen = 1'b0;
    src_data[3*32 +: 32] = 32'h3333_0000;
    for (int n = 0; n < 10 && !seen; n++) begin
      src_valid[3] = 1'b1;
      tick();
      if (eng_ct_valid === 1'b1) seen = 1'b1;
    end
    src_valid = '0;
    for (int n = 1; n <= 16; n++) begin
      tick();
      if (n < 16 && done_valid === 1'b1) begin
        total_cnt++;
        $display("FAIL timeout_early: done_valid at %0d cycles after WAIT entry, expected at 16", n);
      end
    end
    total_cnt++;
    if ({done_valid, done_timeout, done_auth_ok, done_id} !== {1'b1, 1'b1, 1'b0, 2'd3})
      $display("FAIL timeout_done: got dv=%b to=%b ok=%b id=%0d expected 1 1 0 3", done_valid, done_timeout, done_auth_ok, done_id);
    else pass_cnt++;
    tick();
    set_len(0, 1);
    word_tab[0] = 32'h0BAD_F00D;
    req_valid = 4'b0001;
    session(0, 1, 1'b0, 1'b1, 1'b1, 1'b1);
  endtask
`endif

  task automatic test_reset_mid_stream();
    int got;
    set_len(3, 5);
    for (int i = 0; i < 5; i++) word_tab[i] = 32'h5000_0000 + 32'(i);
    req_valid = 4'b1000;
    got = 0;
    for (int n = 0; n < 20 && got < 2; n++) begin
      src_valid[3] = 1'b1;
      src_data[3*32 +: 32] = word_tab[got];
      eng_pt = 32'h1234_5678; eng_pt_valid = 1'b1;
      tick();
      if (req_grant != '0) req_valid = '0;
      if (eng_ct_valid === 1'b1) got++;
    end
    src_valid = '0; eng_pt_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    total_cnt++;
    if (got != 2 || {req_grant, src_ready, eng_sel, eng_rst_n, eng_ct, eng_ct_valid, pt_data, pt_valid, pt_id,
         done_valid, done_id, done_auth_ok, done_len_err, done_timeout} !== '0)
      $display("FAIL mid_reset: got words=%0d grant=%b ready=%b rstn=%b ct=%h ctv=%b pt=%h dv=%b expected 2 words, all 0",
               got, req_grant, src_ready, eng_rst_n, eng_ct, eng_ct_valid, pt_data, done_valid);
    else pass_cnt++;
    repeat (2) tick();
    total_cnt++;
    if (done_valid !== 1'b0)
      $display("FAIL mid_reset_done: got done_valid=%b expected 0", done_valid);
    else pass_cnt++;
    reset_n = 1'b1;
    set_len(1, 1); set_len(3, 2);
    word_tab[0] = 32'h7100_0001;
    req_valid = 4'b1010;
    session(1, 1, 1'b0, 1'b1, 1'b0, 1'b1);
    word_tab[0] = 32'h7300_0001; word_tab[1] = 32'h7300_0002;
    session(3, 2, 1'b0, 1'b1, 1'b1, 1'b1);
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_zero_len();
    test_auth_fail_backpressure();
    test_pt_forward();
`ifdef GCM_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_stream();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
